// File: rtl/addsub_pkg.sv
// Shared types and constants for the group-serial add/subtract unit.
package addsub_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int GROUP_DEF = 4;

    // Slice counter is at least one bit wide so a single-slice build still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_GROUPS = WIDTH_DEF / GROUP_DEF;
    localparam int CNT_W    = cnt_width(N_GROUPS);

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry lookahead: per-bit carries plus group propagate/generate.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             c_in,
    output logic [GROUP-1:0] c_vec,
    output logic             p_out,
    output logic             g_out
);

    // Carry into bit i as a flat sum of products: c_in through all propagates,
    // or any generate j<i through the propagates between j and i.
    function automatic logic carry_into(input int i, input logic [GROUP-1:0] pp,
                                        input logic [GROUP-1:0] gg, input logic c);
        logic res;
        logic prod;
        prod = c;
        for (int k = 0; k < i; k++) prod = prod & pp[k];
        res = prod;
        for (int j = 0; j < i; j++) begin
            prod = gg[j];
            for (int k = j + 1; k < i; k++) prod = prod & pp[k];
            res = res | prod;
        end
        return res;
    endfunction

    always_comb begin
        c_vec = '0;
        for (int i = 0; i < GROUP; i++) c_vec[i] = carry_into(i, p, g, c_in);
        p_out = &p;
        g_out = carry_into(GROUP, p, g, 1'b0);
    end

endmodule

// File: rtl/group_serial_addsub.sv
// Multi-cycle adder/subtractor: one GROUP-bit lookahead slice per clock, LSB first,
// with the inter-slice carry held in a register and valid/ready on both sides.
module group_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GROUP = GROUP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out,
    output logic             ovf
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    localparam int NG = WIDTH / GROUP;
    localparam int CW = cnt_width(NG);
    localparam logic [CW-1:0] LAST = CW'(NG - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             sub_q, sub_d, carry_q, carry_d;
    logic             c_out_q, c_out_d, ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;

    logic [GROUP-1:0] a_s, b_s, p_s, g_s, c_vec, sum_s;
    logic             p_grp, g_grp, c_grp;

    // Operands shift right each slice, so the active slice is always the low GROUP bits.
    assign a_s = a_q[GROUP-1:0];
    assign b_s = b_q[GROUP-1:0];
    assign p_s = a_s | b_s;
    assign g_s = a_s & b_s;

    cla_group #(.GROUP(GROUP)) u_cla (
        .p     (p_s),
        .g     (g_s),
        .c_in  (carry_q),
        .c_vec (c_vec),
        .p_out (p_grp),
        .g_out (g_grp)
    );

    assign sum_s = a_s ^ b_s ^ c_vec;
    assign c_grp = g_grp | (p_grp & carry_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = (sub == SUB) ? ~b_in : b_in;
                    sub_d   = sub;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> GROUP;
                b_d     = b_q >> GROUP;
                s_d     = {sum_s, s_q[WIDTH-1:GROUP]};
                carry_d = c_grp;
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    c_out_d     = c_grp ^ sub_q;
                    ovf_d       = c_vec[GROUP-1] ^ c_grp;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s_out     = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_group_serial_addsub.sv
// Bench for group_serial_addsub: directed corner cases, backpressure, mid-run reset
// and randomized traffic checked by a queue-based scoreboard.
`timescale 1ns/1ps
module tb_group_serial_addsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, c_out, ovf;
    logic [W-1:0] s_out;

    group_serial_addsub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_pushed = 0;
    int  n_seen   = 0;
    bit  rand_ready = 1'b0;
    logic [17:0] exp_q[$];   // {ovf, c_out, s_out}
    logic [17:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain wide arithmetic and sign rules.
    function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic s);
        logic [16:0] r;
        logic        v, c;
        if (!s) begin
            r = {1'b0, a} + {1'b0, b};
            c = r[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
        end else begin
            r = {1'b0, a} - {1'b0, b};
            c = (a < b);
            v = (a[15] != b[15]) && (r[15] != a[15]);
        end
        return {v, c, r[15:0]};
    endfunction

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("s_out", 32'(s_out), 32'(mon_e[15:0]));
                check("c_out", 32'(c_out), 32'(mon_e[16]));
                check("ovf",   32'(ovf),   32'(mon_e[17]));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [17:0] e, input bit keep);
        bit done;
        done = 1'b0;
        a_in = a; b_in = b; sub = s; in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (keep) begin
                    exp_q.push_back(e);
                    n_pushed++;
                end
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) begin
                k = i;
                break;
            end
        end
        if (k == 0) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [17:0] e);
        int lat;
        issue(a, b, s, e, 1'b1);
        wait_valid(lat);
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hold_bad;
        int rises;
        logic [15:0] ra, rb;
        logic        rs;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s_out",     32'(s_out),     32'd0);
        check("rst_c_out",     32'(c_out),     32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(16'h1234, 16'h0FFF, 1'b0, {1'b0, 1'b0, 16'h2233}, 1'b1);
        wait_valid(lat);
        check("latency", 32'(lat), 32'd4);
        @(posedge clk); #1;

        run_op(16'h0000, 16'h0001, 1'b1, {1'b0, 1'b1, 16'hFFFF});
        run_op(16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
        run_op(16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000});

        // Backpressure: result must hold, and an op offered meanwhile must be dropped.
        out_ready = 1'b0;
        issue(16'h8000, 16'h0001, 1'b1, {1'b1, 1'b0, 16'h7FFF}, 1'b1);
        wait_valid(lat);
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                a_in = 16'h1111; b_in = 16'h2222; sub = 1'b0; in_valid = 1'b1;
            end
            if (i == 6) in_valid = 1'b0;
            @(negedge clk);
            if (s_out !== 16'h7FFF || c_out !== 1'b0 || ovf !== 1'b1 ||
                in_ready !== 1'b0 || out_valid !== 1'b1) hold_bad++;
        end
        check("hold_stable", 32'(hold_bad), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_release_ready", 32'(in_ready),  32'd1);
        check("idle_after_release_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Abort an operation with reset while slice 2 is being resolved.
        issue(16'h1234, 16'h1111, 1'b0, 18'd0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_s_out",     32'(s_out),     32'd0);
        check("abort_c_out",     32'(c_out),     32'd0);
        check("abort_ovf",       32'(ovf),       32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        check("abort_no_result", 32'(rises), 32'd0);
        @(posedge clk); #1;
        run_op(16'h0003, 16'h0005, 1'b1, {1'b0, 1'b1, 16'hFFFE});

        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            issue(ra, rb, rs, ref_model(ra, rb, rs), 1'b1);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("results_count", 32'(n_seen), 32'(n_pushed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
